// File: rtl/ecdsa_pkg.sv
// rtl/ecdsa_pkg.sv - shared constants, field offsets and FSM encoding for the signature serializer
package ecdsa_pkg;

  localparam int SIG_BYTES = 65;
  localparam int R_MSB     = 519;
  localparam int S_MSB     = 263;
  localparam int V_MSB     = 7;

  localparam logic [7:0] V_EVEN   = 8'd27;
  localparam logic [7:0] V_ODD    = 8'd28;
  localparam logic [7:0] ERR_CODE = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [255:0] sig_r(input logic [R_MSB:0] sig);
    return sig[R_MSB:S_MSB+1];
  endfunction

  function automatic logic [255:0] sig_s(input logic [R_MSB:0] sig);
    return sig[S_MSB:V_MSB+1];
  endfunction

  // Ethereum recovery id is only meaningful as 27 or 28.
  function automatic logic v_is_valid(input logic [7:0] v);
    return (v == V_EVEN) || (v == V_ODD);
  endfunction

endpackage

// File: rtl/ecdsa_sig_serializer_if.sv
// rtl/ecdsa_sig_serializer_if.sv - byte-wide frame stream toward the host link
interface ecdsa_sig_serializer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/ecdsa_sig_serializer.sv
// rtl/ecdsa_sig_serializer.sv - captures the signer's {r,s,v} result and streams it as a byte frame
module ecdsa_sig_serializer #(
  parameter int         SIG_BYTES = ecdsa_pkg::SIG_BYTES,
  parameter bit         CHECK_V   = 1'b1,
  parameter logic [7:0] ERR_CODE  = ecdsa_pkg::ERR_CODE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SIG_BYTES*8-1:0]     sig_in,
  input  logic                       sig_done,
  input  logic                       sig_error,
  ecdsa_sig_serializer_if.master     tx,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic                       bad_v
);

  import ecdsa_pkg::*;

  localparam int         TOP      = SIG_BYTES*8 - 1;
  localparam logic [6:0] LAST_IDX = 7'(SIG_BYTES - 1);

  state_e             state_q;
  state_e             state_d;
  logic [TOP:0]       shreg_q;
  logic [6:0]         cnt_q;
  logic               overrun_q;
  logic               bad_v_q;

  logic               capture;
  logic               shift_en;
  logic               valid_c;
  logic               last_c;
  logic [7:0]         data_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from state so data/last cannot move during a stall.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    shift_en = 1'b0;
    valid_c  = 1'b0;
    last_c   = 1'b0;
    data_c   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (sig_error) begin
          state_d = ST_ERR;
        end else if (sig_done) begin
          state_d = ST_SEND;
          capture = 1'b1;
        end
      end
      ST_SEND: begin
        valid_c  = 1'b1;
        data_c   = shreg_q[TOP -: 8];
        last_c   = (cnt_q == LAST_IDX);
        shift_en = tx.tx_ready;
        if (tx.tx_ready && last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_ERR: begin
        valid_c = 1'b1;
        data_c  = ERR_CODE;
        last_c  = 1'b1;
        if (tx.tx_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      bad_v_q   <= 1'b0;
    end else begin
      // Anything arriving outside IDLE is dropped; DONE counts as busy.
      overrun_q <= (sig_done || sig_error) && (state_q != ST_IDLE);
      if (capture) begin
        shreg_q <= sig_in;
        cnt_q   <= '0;
        bad_v_q <= CHECK_V ? !v_is_valid(sig_in[V_MSB:0]) : 1'b0;
      end else if (shift_en) begin
        shreg_q <= shreg_q << 8;
        if (!last_c) begin
          cnt_q <= cnt_q + 7'd1;
        end
      end
      if (state_q == ST_DONE) begin
        cnt_q <= '0;
      end
    end
  end

  assign tx.tx_valid = valid_c;
  assign tx.tx_data  = data_c;
  assign tx.tx_last  = last_c;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_DONE);
  assign overrun     = overrun_q;
  assign bad_v       = bad_v_q;

endmodule
